// File: rtl/ghostbus_reg_bank.sv
// ghostbus_reg_bank: ghostbus-decoded bank of NREGS registers with write/read strobes and an RD-deep read pipeline.
// Optional write counter at BASE+NREGS is enabled by defining GHOSTBUS_REG_BANK_WCOUNT_EN.
module ghostbus_reg_bank #(
  parameter int unsigned         AW      = 24,
  parameter int unsigned         DW      = 32,
  parameter int unsigned         RW      = 8,
  parameter int unsigned         NREGS   = 4,
  parameter int unsigned         BASE    = 0,
  parameter int unsigned         RD      = 1,
  parameter logic [NREGS*RW-1:0] INIT    = '0,
  parameter logic [NREGS-1:0]    RO_MASK = '0
) (
  input  logic                  gb_clk,
  input  logic                  gb_rst_n,
  input  logic [AW-1:0]         gb_addr,
  input  logic [DW-1:0]         gb_wdata,
  input  logic                  gb_wen,
  input  logic                  gb_rstb,
  output logic [DW-1:0]         gb_rdata,
  output logic                  gb_rvalid,
  output logic [NREGS*RW-1:0]   regs_out,
  input  logic [NREGS*RW-1:0]   status_in,
  output logic [NREGS-1:0]      wstb,
  output logic [NREGS-1:0]      rstb
);

`ifdef GHOSTBUS_REG_BANK_WCOUNT_EN
  localparam int unsigned NSLOTS = NREGS + 1;
`else
  localparam int unsigned NSLOTS = NREGS;
`endif
  localparam int unsigned IW = (NSLOTS > 1) ? $clog2(NSLOTS) : 1;

  if ((RW < 1) || (RW > DW)) begin : g_err_rw
    $error("ghostbus_reg_bank: RW must be in 1..DW");
  end
  if ((NREGS < 1) || (NREGS > 256)) begin : g_err_nregs
    $error("ghostbus_reg_bank: NREGS must be in 1..256");
  end
  if ((RD < 1) || (RD > 8)) begin : g_err_rd
    $error("ghostbus_reg_bank: RD must be in 1..8");
  end
  // The decoded range must fit below 2^AW, so the address compare never wraps.
  if ((64'(BASE) + 64'(NSLOTS)) > (64'd1 << AW)) begin : g_err_range
    $error("ghostbus_reg_bank: BASE+range exceeds the address space");
  end

  logic [AW-1:0]    w_base;
  logic [AW-1:0]    w_off;
  logic             w_hit;
  logic [IW-1:0]    w_idx;
  logic [NREGS-1:0] w_sel;
  logic [NREGS-1:0] w_wr;
  logic             w_rd_go;
  logic [DW-1:0]    w_rd_data;
  logic [DW-1:0]    w_rd_mux;
  logic             w_unused_ok;

  logic [RW-1:0]    r_regs [NREGS];
  logic [NREGS-1:0] r_wstb;
  logic [NREGS-1:0] r_rstb;
  logic [RD-1:0]    r_pv;
  logic [DW-1:0]    r_pd [RD];

  assign w_base  = AW'(BASE);
  assign w_off   = gb_addr - w_base;
  assign w_hit   = (gb_addr >= w_base) && ({1'b0, w_off} < (AW+1)'(NSLOTS));
  assign w_idx   = w_off[IW-1:0];
  assign w_rd_go = gb_rstb && w_hit;
  assign w_unused_ok = &{1'b0, gb_wdata, status_in};

  // Per-register select and accepted-write vector.
  always_comb begin
    w_sel = '0;
    w_wr  = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_sel[i] = w_hit && (w_idx == IW'(i));
      w_wr[i]  = gb_wen && w_sel[i] && !RO_MASK[i];
    end
  end

  // Read source mux: zero-extended register value, or the status slot for RO registers.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NREGS; i++) begin
      w_rd_data = w_rd_data | (w_sel[i] ? DW'(RO_MASK[i] ? status_in[i*RW +: RW] : r_regs[i]) : '0);
    end
  end

`ifdef GHOSTBUS_REG_BANK_WCOUNT_EN
  logic [DW-1:0] r_wcount;
  logic          w_cnt_sel;

  assign w_cnt_sel = w_hit && (w_idx == IW'(NREGS));
  assign w_rd_mux  = w_cnt_sel ? r_wcount : w_rd_data;

  // Count of accepted writes to RW registers; wraps naturally.
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      r_wcount <= '0;
    end else if (|w_wr) begin
      r_wcount <= r_wcount + DW'(1'b1);
    end
  end
`else
  assign w_rd_mux = w_rd_data;
`endif

  // Register storage; RO slots never load and hold zero.
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= RO_MASK[i] ? '0 : INIT[i*RW +: RW];
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_wr[i]) begin
          r_regs[i] <= gb_wdata[RW-1:0];
        end
      end
    end
  end

  // Strobes are one-cycle pulses aligned with the updated register / captured read.
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      r_wstb <= '0;
      r_rstb <= '0;
    end else begin
      r_wstb <= w_wr;
      r_rstb <= gb_rstb ? w_sel : '0;
    end
  end

  // Read pipeline; data is zeroed in bubbles so gb_rdata can be OR-combined on the bus.
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      r_pv <= '0;
      for (int s = 0; s < RD; s++) begin
        r_pd[s] <= '0;
      end
    end else begin
      r_pv[0] <= w_rd_go;
      r_pd[0] <= w_rd_go ? w_rd_mux : '0;
      for (int s = 1; s < RD; s++) begin
        r_pv[s] <= r_pv[s-1];
        r_pd[s] <= r_pd[s-1];
      end
    end
  end

  // RO slots present zero on regs_out.
  always_comb begin
    regs_out = '0;
    for (int i = 0; i < NREGS; i++) begin
      regs_out[i*RW +: RW] = RO_MASK[i] ? '0 : r_regs[i];
    end
  end

  assign gb_rvalid = r_pv[RD-1];
  assign gb_rdata  = r_pd[RD-1];
  assign wstb      = r_wstb;
  assign rstb      = r_rstb;

endmodule

// File: tb/tb_ghostbus_reg_bank.sv
// Scoreboard bench for ghostbus_reg_bank: directed scenarios followed by randomized bus traffic.
module tb_ghostbus_reg_bank;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int RW = 8;
  localparam int NREGS = 4;
  localparam int BASE = 'h100;
  localparam int RD = 3;
  localparam logic [NREGS*RW-1:0] INIT = 32'h7700_22C3;
  localparam logic [NREGS-1:0] RO_MASK = 4'b0001;
`ifdef GHOSTBUS_REG_BANK_WCOUNT_EN
  localparam int NSLOTS = NREGS + 1;
`else
  localparam int NSLOTS = NREGS;
`endif

  logic                gb_clk;
  logic                gb_rst_n;
  logic [AW-1:0]       gb_addr;
  logic [DW-1:0]       gb_wdata;
  logic                gb_wen;
  logic                gb_rstb;
  logic [DW-1:0]       gb_rdata;
  logic                gb_rvalid;
  logic [NREGS*RW-1:0] regs_out;
  logic [NREGS*RW-1:0] status_in;
  logic [NREGS-1:0]    wstb;
  logic [NREGS-1:0]    rstb;

  ghostbus_reg_bank #(
    .AW(AW), .DW(DW), .RW(RW), .NREGS(NREGS), .BASE(BASE), .RD(RD),
    .INIT(INIT), .RO_MASK(RO_MASK)
  ) dut (
    .gb_clk(gb_clk), .gb_rst_n(gb_rst_n), .gb_addr(gb_addr), .gb_wdata(gb_wdata),
    .gb_wen(gb_wen), .gb_rstb(gb_rstb), .gb_rdata(gb_rdata), .gb_rvalid(gb_rvalid),
    .regs_out(regs_out), .status_in(status_in), .wstb(wstb), .rstb(rstb)
  );

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } rd_t;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_pass = 0;
  bit  mon_en = 1'b0;
  rd_t rq[$];
  logic [NREGS-1:0]    ews[int];
  logic [NREGS-1:0]    ers[int];
  logic [NREGS*RW-1:0] ero[int];
  logic [RW-1:0]       m_regs[NREGS];
  logic [DW-1:0]       m_wcount;
  logic [NREGS*RW-1:0] cur_st;
  logic [NREGS*RW-1:0] snap;

  always #5 gb_clk = ~gb_clk;
  always @(posedge gb_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [NREGS*RW-1:0] model_regs_out();
    logic [NREGS*RW-1:0] v;
    v = '0;
    for (int i = 0; i < NREGS; i++) if (!RO_MASK[i]) v[i*RW +: RW] = m_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = INIT[i*RW +: RW];
    m_wcount = '0;
    rq.delete();
    ews.delete();
    ers.delete();
    ero.delete();
  endtask

  // One bus cycle: update the reference model, queue expectations, drive, advance.
  task automatic bus_cycle(input bit wen, input bit rd, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [NREGS*RW-1:0] st);
    longint a;
    bit hit;
    int idx;
    logic [NREGS-1:0] ws;
    logic [NREGS-1:0] rs;
    rd_t e;
    a   = longint'(addr);
    hit = (a >= BASE) && (a < BASE + NSLOTS);
    idx = int'(a - BASE);
    ws  = '0;
    rs  = '0;
    if (rd && hit) begin
      if (idx < NREGS) begin
        e.data = RO_MASK[idx] ? DW'(st[idx*RW +: RW]) : DW'(m_regs[idx]);
        rs[idx] = 1'b1;
      end else begin
        e.data = m_wcount;
      end
      e.due = cyc + RD;
      rq.push_back(e);
    end
    if (wen && hit && (idx < NREGS) && !RO_MASK[idx]) begin
      m_regs[idx] = wdata[RW-1:0];
      m_wcount = m_wcount + 1'b1;
      ws[idx] = 1'b1;
    end
    ews[cyc+1] = ws;
    ers[cyc+1] = rs;
    ero[cyc+1] = model_regs_out();
    gb_wen = wen; gb_rstb = rd; gb_addr = addr; gb_wdata = wdata; status_in = st;
    @(posedge gb_clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) bus_cycle(1'b0, 1'b0, '0, '0, cur_st);
  endtask

  // Monitor: compares outputs every cycle against the queued expectations.
  always @(negedge gb_clk) begin
    if (mon_en) begin
      if (gb_rvalid) begin
        if (rq.size() == 0) begin
          chk("spurious_rvalid", 64'(gb_rvalid), 64'd0);
        end else begin
          chk("rdata", 64'(gb_rdata), 64'(rq[0].data));
          chk("rlatency", 64'(cyc), 64'(rq[0].due));
          void'(rq.pop_front());
        end
      end else begin
        chk("rdata_idle_zero", 64'(gb_rdata), 64'd0);
        if ((rq.size() > 0) && (rq[0].due <= cyc)) begin
          chk("missing_rvalid", 64'(gb_rvalid), 64'd1);
          void'(rq.pop_front());
        end
      end
      chk("wstb", 64'(wstb), ews.exists(cyc) ? 64'(ews[cyc]) : 64'd0);
      chk("rstb", 64'(rstb), ers.exists(cyc) ? 64'(ers[cyc]) : 64'd0);
      chk("regs_out", 64'(regs_out), ero.exists(cyc) ? 64'(ero[cyc]) : 64'(model_regs_out()));
    end
  end

  initial begin
    gb_clk = 1'b0; gb_rst_n = 1'b0;
    gb_wen = 1'b0; gb_rstb = 1'b0; gb_addr = '0; gb_wdata = '0;
    cur_st = 32'h0000_003C;
    status_in = cur_st;
    model_reset();
    repeat (3) @(posedge gb_clk);
    #1 gb_rst_n = 1'b1;
    @(negedge gb_clk);
    chk("reset_regs_out", 64'(regs_out), 64'h7700_2200);
    chk("reset_rvalid", 64'(gb_rvalid), 64'd0);
    chk("reset_rdata", 64'(gb_rdata), 64'd0);
    chk("reset_strobes", 64'({wstb, rstb}), 64'd0);
    @(posedge gb_clk);
    #1 mon_en = 1'b1;

    // Back-to-back reads of every register.
    for (int i = 0; i < NREGS; i++) bus_cycle(1'b0, 1'b1, AW'(BASE + i), '0, cur_st);
    bus_cycle(1'b1, 1'b0, AW'(BASE + 2), 32'hDEAD_BEA5, cur_st);
    chk("wr_regs_out_slot2", 64'(regs_out[23:16]), 64'hA5);
    chk("wr_wstb_slot2", 64'(wstb), 64'h4);
    bus_cycle(1'b0, 1'b1, AW'(BASE + 2), '0, cur_st);
    chk("rd_rstb_slot2", 64'(rstb), 64'h4);
    // Write to the RO register is dropped.
    bus_cycle(1'b1, 1'b0, AW'(BASE), 32'h0000_00FF, cur_st);
    chk("ro_wstb", 64'(wstb), 64'd0);
    chk("ro_regs_out", 64'(regs_out[7:0]), 64'd0);
    bus_cycle(1'b0, 1'b1, AW'(BASE), '0, cur_st);
    // Boundary addresses around the bank.
    bus_cycle(1'b0, 1'b1, AW'(BASE - 1), '0, cur_st);
    bus_cycle(1'b0, 1'b1, AW'(BASE + NREGS), '0, cur_st);
    bus_cycle(1'b0, 1'b1, AW'(BASE + NREGS + 1), '0, cur_st);
    snap = regs_out;
    bus_cycle(1'b1, 1'b0, AW'(BASE + NREGS), 32'h1234_5678, cur_st);
    chk("miss_write_no_change", 64'(regs_out), 64'(snap));
    // Same-cycle write and read of one register returns the old value.
    bus_cycle(1'b1, 1'b1, AW'(BASE + 1), 32'h0000_0011, cur_st);
    bus_cycle(1'b0, 1'b1, AW'(BASE + 1), '0, cur_st);
    idle(RD + 1);

    // Reset asserted while a read is in flight.
    bus_cycle(1'b0, 1'b1, AW'(BASE + 3), '0, cur_st);
    idle(1);
    gb_rst_n = 1'b0;
    model_reset();
    idle(3);
    gb_rst_n = 1'b1;
    idle(RD + 2);
    chk("post_reset_regs_out", 64'(regs_out), 64'h7700_2200);

    // Three accepted writes, then the counter slot (a miss when the counter is absent).
    for (int i = 1; i < NREGS; i++) bus_cycle(1'b1, 1'b0, AW'(BASE + i), $urandom, cur_st);
    bus_cycle(1'b0, 1'b1, AW'(BASE + NREGS), '0, cur_st);
    idle(RD + 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic [AW-1:0] addr;
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 8) addr = AW'(BASE - 2 + r);
      else addr = AW'($urandom);
      cur_st = $urandom;
      bus_cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 70), addr, $urandom, cur_st);
    end
    idle(RD + 3);
    chk("drain_queue_empty", 64'(rq.size()), 64'd0);
    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/ghostbus_reg_bank.md
Name: ghostbus_reg_bank

Overview:
Parametrised, ghostbus-decoded bank of NREGS host-accessible registers. It generalises the single hand-placed register with strobes into a reusable block with the following properties:
- Configurable base address, register width and count.
- Per-register read-only/read-write mode.
- Per-register write and read strobes.
- Pipelined read path of configurable depth.
It sits on the ghostbus alongside other decoded peripherals. Its gb_rdata is zero outside valid cycles so the bus can OR-combine it.

Parameters:
AW, 24, ghostbus address width
DW, 32, ghostbus data width
RW, 8, register width; 1 <= RW <= DW
NREGS, 4, number of registers; 1..256
BASE, 0, first bus address of the bank
RD, 1, read latency in cycles; 1..8
INIT, 0, NREGS*RW reset values; register i uses bits [i*RW +: RW]
RO_MASK, 0, NREGS bits; bit i set makes register i read-only and sourced from status_in

Ports:
gb_clk  input  1  ghostbus clock
gb_rst_n  input  1  reset, asynchronous, active-low
gb_addr  input  AW  bus address
gb_wdata  input  DW  bus write data
gb_wen  input  1  write enable / write strobe
gb_rstb  input  1  read strobe
gb_rdata  output  DW  read data; zero unless gb_rvalid
gb_rvalid  output  1  read data valid
regs_out  output  NREGS*RW  current RW register values; RO slots drive 0
status_in  input  NREGS*RW  read-only register sources; synchronous to gb_clk
wstb  output  NREGS  one-cycle pulse per register written
rstb  output  NREGS  one-cycle pulse per register read

Behaviour:
- Decode:
  - hit = (gb_addr >= BASE) && (gb_addr < BASE+NREGS); index = gb_addr - BASE.
  - Compare at AW bits with no wrap; a bank whose range extends past 2^AW-1 is a parameter error, caught by an elaboration-time check.
- Write: on a gb_clk edge with gb_wen && hit && !RO_MASK[index]:
  - reg[index] <= gb_wdata[RW-1:0]; upper wdata bits are ignored.
  - wstb[index] = 1 for the following cycle, aligned with the new value on regs_out.
  - Writes to RO registers and misses change nothing and raise no strobe.
- Read: on an edge with gb_rstb && hit:
  - Capture stage 0: zero-extended reg[index], or status_in slot if RO.
  - rstb[index] pulses the following cycle, for both RO and RW registers.
  - Data shifts through RD stages; gb_rvalid=1 and gb_rdata=data exactly RD cycles after the rstb edge, for one cycle.
- Pipeline throughput: back-to-back reads every cycle are supported, one result per cycle, in order. A miss inserts a bubble: rvalid=0, rdata=0.
- Same-cycle write and read to the same index: the read returns the pre-write value; both strobes fire.
- gb_wen and gb_rstb on different indices in the same cycle are independent.
- No internal synchronisers; status_in is the source's responsibility.
- Reset (async assert, sync-safe release):
  - Registers <= INIT.
  - wstb, rstb, gb_rvalid = 0; gb_rdata = 0.
  - Read pipeline flushed; a read in flight at reset assertion never produces rvalid.

Optional Feature:
Macro GHOSTBUS_REG_BANK_WCOUNT_EN.
- Defined: adds a read-only register at address BASE+NREGS, so the decode range becomes NREGS+1.
  - Holds a DW-bit count of accepted writes: RW registers only, hits only.
  - Wraps from 2^DW-1 to 0; reset value 0.
  - Readable through the same RD pipeline with no rstb pulse; writes to it are ignored.
- Undefined: that address is a miss, and no counter logic is generated.

Test Plan:
1. Defaults; release reset -> regs_out=0, gb_rdata=0, gb_rvalid=0. Then read addr 0..3 on consecutive cycles -> rvalid on 4 consecutive cycles starting 1 cycle later, rdata=0 each.
2. Write 0xDEADBEA5 to addr 2 -> next cycle regs_out[23:16]=0xA5, wstb=4'b0100 for one cycle. Read addr 2 with RD=3 -> rdata=0x000000A5 with rvalid exactly 3 cycles after rstb, rstb=4'b0100.
3. RO_MASK=4'b0001, status_in[7:0]=0x3C. Write 0xFF to addr 0 -> no wstb, regs_out[7:0]=0. Read addr 0 -> rdata=0x3C.
4. BASE=0x100. Read 0x0FF and 0x104 -> rvalid stays 0, rdata=0. Write 0x104 -> no register changes.
5. Same cycle write 0x11 and read of addr 1 holding 0x22 -> rdata=0x22; a subsequent read returns 0x11.
6. RD=4, issue read, assert gb_rst_n=0 two cycles later -> no rvalid ever appears. With GHOSTBUS_REG_BANK_WCOUNT_EN: 3 writes then read BASE+NREGS -> rdata=3.
